// File: rtl/mac_classifier.sv
// mac_classifier: pipelined fixed-point dot products per class with arg-max; SAT_ACC_EN selects saturating accumulation
module mac_classifier #(
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_CLASSES = 10,
  parameter int PIX_W       = 8,
  parameter int WT_W        = 16,
  parameter int ACC_W       = 32,
  parameter int PADDR_W     = 10,
  parameter int WADDR_W     = 13,
  parameter int CLS_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [PADDR_W-1:0] pic_addr,
  input  logic [PIX_W-1:0]   pic_data,
  output logic [WADDR_W-1:0] wt_addr,
  input  logic [WT_W-1:0]    wt_data,
  output logic               score_valid,
  output logic [CLS_W-1:0]   score_class,
  output logic [ACC_W-1:0]   score,
  output logic               done,
  output logic [CLS_W-1:0]   result_class,
  output logic [ACC_W-1:0]   result_score
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [PADDR_W-1:0] pix_q, pix_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic pix_last, cls_last, accept;
  logic v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, sv_q;
  logic [CLS_W-1:0] c1_q, c2_q, score_class_q, result_class_q;
  logic signed [PIX_W+WT_W:0] pix_s, wt_s, mul;
  logic signed [ACC_W-1:0] prod_q, acc_q, acc_d, score_q, result_score_q;

  assign pix_last = pix_q == PADDR_W'(NUM_PIXELS - 1);
  assign cls_last = cls_q == CLS_W'(NUM_CLASSES - 1);
  assign accept   = state_q == IDLE && start;
  assign pix_s    = {{(WT_W + 1){1'b0}}, pic_data};
  assign wt_s     = {{(PIX_W + 1){wt_data[WT_W-1]}}, wt_data};
  assign mul      = pix_s * wt_s;

`ifdef SAT_ACC_EN
  logic [ACC_W:0] sum;
  assign sum   = {acc_q[ACC_W-1], acc_q} + {prod_q[ACC_W-1], prod_q};
  assign acc_d = f2_q ? prod_q :
                 sum[ACC_W] != sum[ACC_W-1] ? {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
  assign acc_d = f2_q ? prod_q : acc_q + prod_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state: issue every pair back to back, then drain until the pipe is empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ISSUE : IDLE;
      ISSUE:   state_d = (pix_last && cls_last) ? DRAIN : ISSUE;
      DRAIN:   state_d = (!v1_q && !v2_q) ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == FIN;
  end

  // Address counters: pixel index nested inside class index; hold outside ISSUE
  always_comb begin
    pix_d   = pix_q;
    cls_d   = cls_q;
    waddr_d = waddr_q;
    if (accept) begin
      pix_d   = '0;
      cls_d   = '0;
      waddr_d = '0;
    end else if (state_q == ISSUE && !(pix_last && cls_last)) begin
      pix_d   = pix_last ? '0 : pix_q + 1'b1;
      cls_d   = pix_last ? cls_q + 1'b1 : cls_q;
      waddr_d = waddr_q + 1'b1;
    end
  end

  // Datapath: tag pipeline, multiply, accumulate, score strobe and arg-max
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q          <= '0;
      cls_q          <= '0;
      waddr_q        <= '0;
      {v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, sv_q} <= '0;
      c1_q           <= '0;
      c2_q           <= '0;
      prod_q         <= '0;
      acc_q          <= '0;
      score_q        <= '0;
      score_class_q  <= '0;
      result_class_q <= '0;
      result_score_q <= '0;
    end else begin
      pix_q   <= pix_d;
      cls_q   <= cls_d;
      waddr_q <= waddr_d;
      v1_q    <= state_q == ISSUE;
      f1_q    <= pix_q == '0;
      l1_q    <= pix_last;
      c1_q    <= cls_q;
      v2_q    <= v1_q;
      f2_q    <= f1_q;
      l2_q    <= l1_q;
      c2_q    <= c1_q;
      prod_q  <= ACC_W'(mul);
      sv_q    <= v2_q && l2_q;
      if (v2_q) acc_q <= acc_d;
      if (v2_q && l2_q) begin
        score_q       <= acc_d;
        score_class_q <= c2_q;
      end
      if (accept) begin
        result_class_q <= '0;
        result_score_q <= '0;
      end else if (sv_q && (score_class_q == '0 || score_q > result_score_q)) begin
        result_class_q <= score_class_q;
        result_score_q <= score_q;
      end
    end
  end

  assign pic_addr     = pix_q;
  assign wt_addr      = waddr_q;
  assign score_valid  = sv_q;
  assign score_class  = score_class_q;
  assign score        = score_q;
  assign result_class = result_class_q;
  assign result_score = result_score_q;
endmodule
